// File: rtl/multiplier.sv
// Sequential radix-2 shift-add 32x32 multiplier for the HI/LO path; dataOut = {HI, LO}.
// Optional signed MULT support is enabled by defining MULT_SIGNED_EN.
module multiplier #(
   parameter int          WIDTH = 32,
   parameter logic [5:0]  MULTU = 6'b011001,
   parameter logic [5:0]  MULT  = 6'b011000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   input  logic [5:0]           Signal,
   output logic [2*WIDTH-1:0]   dataOut,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   prod;
   logic [CW-1:0]        counter;

   logic                 start;
   logic                 held;
   logic [WIDTH-1:0]     load_a;
   logic [WIDTH-1:0]     load_b;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   next_prod;
   logic [2*WIDTH-1:0]   result;

`ifdef MULT_SIGNED_EN
   logic [5:0]           opcode;
   logic                 neg;
   logic                 is_mult;
   logic                 neg_load;

   always_comb begin
      is_mult  = (Signal == MULT);
      start    = (Signal == MULTU) || is_mult;
      held     = (Signal == opcode);
      load_a   = (is_mult && dataA[WIDTH-1]) ? -dataA : dataA;
      load_b   = (is_mult && dataB[WIDTH-1]) ? -dataB : dataB;
      neg_load = is_mult && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
   end
`else
   always_comb begin
      start  = (Signal == MULTU);
      held   = start;
      load_a = dataA;
      load_b = dataB;
   end
`endif

   // 33-bit upper sum keeps the carry, which becomes the new MSB after the shift
   always_comb begin
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0])
         sum = sum + {1'b0, mcand};
      next_prod = {sum, prod[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
      result = neg ? -next_prod : next_prod;
`else
      result = next_prod;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         mcand   <= '0;
         prod    <= '0;
         counter <= '0;
         dataOut <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef MULT_SIGNED_EN
         opcode  <= '0;
         neg     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand   <= load_a;
                  prod    <= {{WIDTH{1'b0}}, load_b};
                  counter <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
`ifdef MULT_SIGNED_EN
                  opcode  <= Signal;
                  neg     <= neg_load;
`endif
               end
            end
            RUN: begin
               if (held) begin
                  prod    <= next_prod;
                  counter <= counter + 1'b1;
                  if (counter == LAST) begin
                     dataOut <= result;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            DONE: begin
               if (!held)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: expected products are queued at issue and
// checked by a monitor on every done pulse.
module tb_multiplier;

   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] MULT  = 6'b011000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   dataA = '0;
   logic [31:0]   dataB = '0;
   logic [5:0]    Signal = '0;
   logic [63:0]   dataOut;
   logic          busy;
   logic          done;

   int checks = 0;
   int fails  = 0;
   logic [63:0] expq[$];

   multiplier dut (
      .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
      .Signal(Signal), .dataOut(dataOut), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      dataA  = a;
      dataB  = b;
      Signal = MULTU;
      expq.push_back(exp);
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         if (done) begin
            if (expq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_done: got dataOut 0x%016h with no product pending", dataOut);
            end else begin
               check("product", dataOut, expq.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // reset
      tick(2);
      reset = 1'b1;
      tick(1);
      check("reset_dataOut", dataOut, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);

      // 3 x 5 with latency and hold checks
      issue(32'd3, 32'd5, 64'h0000_0000_0000_000F);
      tick(1);
      check("busy_after_load", {63'd0, busy}, 64'd1);
      tick(31);
      check("busy_at_edge32", {63'd0, busy}, 64'd1);
      check("no_done_at_edge32", {63'd0, done}, 64'd0);
      tick(1);
      check("done_at_edge33", {63'd0, done}, 64'd1);
      check("busy_clear_at_edge33", {63'd0, busy}, 64'd0);
      tick(5);
      check("hold_done_low", {63'd0, done}, 64'd0);
      check("hold_busy_low", {63'd0, busy}, 64'd0);
      check("hold_dataOut", dataOut, 64'h0000_0000_0000_000F);
      Signal = '0;
      tick(1);

      // max operands: carry into bit 32 of the upper sum
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      tick(33);
      check("done_max", {63'd0, done}, 64'd1);
      Signal = '0;
      tick(1);

      // abort after 10 iterations, then re-issue
      dataA  = 32'h1234_5678;
      dataB  = 32'h9ABC_DEF0;
      Signal = MULTU;
      tick(11);
      Signal = '0;
      tick(1);
      check("abort_busy", {63'd0, busy}, 64'd0);
      tick(2);
      check("abort_keeps_dataOut", dataOut, 64'hFFFF_FFFE_0000_0001);
      issue(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
      tick(33);
      check("done_reissue", {63'd0, done}, 64'd1);
      Signal = '0;
      tick(1);

      // reset during iteration 20
      dataA  = 32'd7;
      dataB  = 32'd9;
      Signal = MULTU;
      tick(21);
      reset = 1'b0;
      tick(1);
      check("midrun_reset_dataOut", dataOut, 64'd0);
      check("midrun_reset_busy", {63'd0, busy}, 64'd0);
      check("midrun_reset_done", {63'd0, done}, 64'd0);
      reset  = 1'b1;
      Signal = '0;
      tick(1);

      // zero operand takes full latency
      issue(32'd0, 32'hDEAD_BEEF, 64'd0);
      tick(32);
      check("zero_busy_edge32", {63'd0, busy}, 64'd1);
      tick(1);
      check("zero_done_edge33", {63'd0, done}, 64'd1);
      Signal = '0;
      tick(1);

      // operands changed after load are ignored
      issue(32'd2, 32'd3, 64'd6);
      tick(1);
      dataA = 32'h0000_FFFF;
      dataB = 32'h0000_FFFF;
      tick(32);
      check("opchange_done", {63'd0, done}, 64'd1);
      Signal = '0;
      tick(1);

      // signed multiply code
      dataA  = 32'hFFFF_FFFD;
      dataB  = 32'd5;
      Signal = MULT;
`ifdef MULT_SIGNED_EN
      expq.push_back(64'hFFFF_FFFF_FFFF_FFF1);
      tick(33);
      check("mult_done", {63'd0, done}, 64'd1);
`else
      tick(1);
      check("mult_ignored_busy", {63'd0, busy}, 64'd0);
      tick(34);
      check("mult_ignored_busy_late", {63'd0, busy}, 64'd0);
      check("mult_ignored_dataOut", dataOut, 64'd6);
`endif
      Signal = '0;
      tick(2);

      check("scoreboard_drained", 64'(expq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned 32x32 multiplier for the MIPS pipeline's HI/LO path; counterpart of the divider.
- Driven by the same 6-bit ALU-control Signal.
- Radix-2 shift-add: one iteration per clock, 32 iterations, 64-bit product on dataOut ({HI, LO}).
- dataOut holds the product until the next completed multiply or reset.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- MULTU, 6'b011001, Signal code that starts/holds an unsigned multiply.
- MULT, 6'b011000, Signal code for signed multiply; used only with MULT_SIGNED_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- dataA  input  WIDTH  multiplicand; sampled only on the load edge.
- dataB  input  WIDTH  multiplier; sampled only on the load edge.
- Signal  input  6  ALU-control code; must stay MULTU for the whole operation.
- dataOut  output  2*WIDTH  last completed product, {HI, LO}.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse on the edge the product is written.

Behaviour:
- Reset (reset==0 at a rising edge), from any state including mid-RUN:
  - state=IDLE, dataOut=0, busy=0, done=0, counter=0, internal registers=0.
  - Reset has priority over every other event.
- Internal registers:
  - mcand[WIDTH-1:0].
  - prod[2*WIDTH-1:0].
  - carry-capable upper sum of WIDTH+1 bits.
  - counter: 6 bits, range 0..32.
- IDLE:
  - If Signal==MULTU: mcand<=dataA, prod<={0, dataB}, counter<=0, busy<=1, go to RUN.
  - Otherwise stay in IDLE; dataOut unchanged.
- RUN, Signal==MULTU, each edge:
  - sum = prod[0] ? {1'b0, prod[63:32]} + {1'b0, mcand} : {1'b0, prod[63:32]}.
  - prod <= {sum[32:0], prod[31:1]} (33-bit sum, logical right shift; the carry is never lost).
  - counter++.
  - On the edge where counter goes 31->32: dataOut<=new prod, done<=1, busy<=0, go to DONE.
- RUN, Signal!=MULTU (abort):
  - Go to IDLE, busy<=0.
  - dataOut keeps its previous value; no done pulse.
- DONE:
  - done deasserts on the next edge.
  - Stay in DONE while Signal==MULTU; the block does not restart on a held code.
  - When Signal!=MULTU, go to IDLE.
  - A new multiply needs Signal to leave MULTU for at least one cycle.
- Latency: load edge + 32 iteration edges. The product is visible on dataOut, with done=1, after the 33rd rising edge counted from the first edge that samples Signal==MULTU in IDLE.
- Operand changes after the load edge have no effect.
- Widths:
  - Unsigned only by default.
  - The full 64-bit product is exact for all inputs; maximum is 0xFFFFFFFE00000001.
  - There is no overflow indication.
- Zero handling: an operand of 0 still takes the full 32 iterations (no early termination) and gives dataOut=0.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - Signal==MULT also starts an operation; in IDLE, MULT and MULTU both start.
  - Operands are replaced by their absolute values at load, and the sign flag is the XOR of dataA[31] and dataB[31].
  - On completion, dataOut is the two's-complement negation of prod if the sign flag is set.
  - During RUN and DONE, "held" means Signal equals the code that started the operation; any other value aborts from RUN or releases DONE.
  - -2^31 magnitude is handled as unsigned 0x80000000.
- Not defined:
  - MULT is treated like any non-MULTU code: idle in IDLE, abort in RUN.
  - No sign logic is synthesised.

Test Plan:
- reset=0 for 2 cycles, then reset=1 with Signal=0 -> dataOut=0, busy=0, done=0.
- dataA=3, dataB=5, Signal=MULTU held -> busy high for 32 cycles; after the 33rd edge dataOut=0x000000000000000F with a single done pulse; dataOut holds while Signal stays MULTU, and there is no second done.
- dataA=0xFFFFFFFF, dataB=0xFFFFFFFF -> dataOut=0xFFFFFFFE00000001 (exercises the carry into bit 32 of the sum).
- Start 0x12345678 x 0x9ABCDEF0, then drop Signal to 0 after 10 iterations -> IDLE, no done, dataOut keeps its prior value. Re-issue and hold the full 33 edges -> dataOut=0x0B00EA4E242D2080.
- Start a multiply, assert reset=0 at iteration 20 -> next edge dataOut=0, busy=0, state IDLE. Operands changed mid-RUN in a separate run -> result uses the load-edge values.
- With MULT_SIGNED_EN, Signal=MULT, dataA=0xFFFFFFFD (-3), dataB=5 -> dataOut=0xFFFFFFFFFFFFFFF1. Without the macro the same stimulus -> busy stays 0, dataOut unchanged.
